// File: rtl/io_stream_shift_buffer.sv
// -----------------------------------------------------------------------------
// io_stream_shift_buffer
//
// Shift-queue of FIFO_SIZE elements with an explicit occupancy count. The
// streaming side pushes/pops LANES elements per beat; the parallel side loads
// or views the whole array at once. Slot 0 always holds the oldest element,
// valid elements occupy slots 0..count-1, and every slot at or above count is
// kept at zero so o_data is a clean view of the queue contents.
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_clear      synchronous flush (highest synchronous priority)
//   i_load       synchronous parallel load from i_data, count -> FIFO_SIZE
//   i_data       parallel load data, slot i = [i*DATA_WIDTH +: DATA_WIDTH]
//   o_data       registered view of all slots, same packing
//   i_in_valid   input beat valid
//   o_in_ready   buffer can accept a beat
//   i_in_data    input beat, lane k = [k*DATA_WIDTH +: DATA_WIDTH]
//   o_out_valid  output beat available
//   i_out_ready  consumer takes a beat
//   o_out_data   output beat = slots 0..LANES-1
//   o_count      number of valid elements
//   o_full       count == FIFO_SIZE
//   o_empty      count == 0
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. ready/valid here are derived only from the count register and
// i_clear/i_load, never from the partner's valid/ready, so there is no
// combinational loop. A producer holds its beat stable until accepted. During
// a clear or load cycle both handshakes are forced low.
// -----------------------------------------------------------------------------
module io_stream_shift_buffer #(
   parameter  int DATA_WIDTH = 16,
   parameter  int FIFO_SIZE  = 256,
   parameter  int LANES      = 1,
   localparam int CNT_W      = $clog2(FIFO_SIZE + 1)
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_clear,
   input  logic                            i_load,
   input  logic [FIFO_SIZE*DATA_WIDTH-1:0] i_data,
   output logic [FIFO_SIZE*DATA_WIDTH-1:0] o_data,
   input  logic                            i_in_valid,
   output logic                            o_in_ready,
   input  logic [LANES*DATA_WIDTH-1:0]     i_in_data,
   output logic                            o_out_valid,
   input  logic                            i_out_ready,
   output logic [LANES*DATA_WIDTH-1:0]     o_out_data,
   output logic [CNT_W-1:0]                o_count,
   output logic                            o_full,
   output logic                            o_empty
);

   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_SIZE);
   localparam logic [CNT_W-1:0] LANES_CNT = CNT_W'(LANES);
   localparam logic [CNT_W-1:0] ROOM_CNT  = CNT_W'(FIFO_SIZE - LANES);

   logic [DATA_WIDTH-1:0] slots_q [FIFO_SIZE];
   logic [DATA_WIDTH-1:0] slots_d [FIFO_SIZE];
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_d;
   logic [CNT_W-1:0]      wr_base;
   logic                  push;
   logic                  pop;

   assign o_in_ready  = !i_clear && !i_load && (count_q <= ROOM_CNT);
   assign o_out_valid = !i_clear && !i_load && (count_q >= LANES_CNT);
   assign push        = i_in_valid && o_in_ready;
   assign pop         = o_out_valid && i_out_ready;

   always_comb begin
      slots_d = slots_q;
      count_d = count_q;
      wr_base = count_q;
      if (i_clear) begin
         for (int i = 0; i < FIFO_SIZE; i++) slots_d[i] = '0;
         count_d = '0;
      end else if (i_load) begin
         for (int i = 0; i < FIFO_SIZE; i++) slots_d[i] = i_data[i*DATA_WIDTH +: DATA_WIDTH];
         count_d = FULL_CNT;
      end else begin
         if (pop) begin
            // Shift down one beat; the vacated top beat refills with zero.
            for (int i = 0; i < FIFO_SIZE - LANES; i++) slots_d[i] = slots_q[i + LANES];
            for (int i = FIFO_SIZE - LANES; i < FIFO_SIZE; i++) slots_d[i] = '0;
            // After the shift the first free slot sits one beat lower.
            wr_base = count_q - LANES_CNT;
         end
         if (push) begin
            for (int i = 0; i < FIFO_SIZE; i++) begin
               for (int k = 0; k < LANES; k++) begin
                  if (i == int'(wr_base) + k) slots_d[i] = i_in_data[k*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
         if (push && !pop) count_d = count_q + LANES_CNT;
         else if (pop && !push) count_d = count_q - LANES_CNT;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < FIFO_SIZE; i++) slots_q[i] <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < FIFO_SIZE; i++) slots_q[i] <= slots_d[i];
         count_q <= count_d;
      end
   end

   for (genvar g = 0; g < FIFO_SIZE; g++) begin : g_view
      assign o_data[g*DATA_WIDTH +: DATA_WIDTH] = slots_q[g];
   end

   for (genvar g = 0; g < LANES; g++) begin : g_out
      assign o_out_data[g*DATA_WIDTH +: DATA_WIDTH] = slots_q[g];
   end

   assign o_count = count_q;
   assign o_full  = (count_q == FULL_CNT);
   assign o_empty = (count_q == '0);

endmodule
